// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD controller.
//   state_t   - controller states
//   SEL_EXT / SEL_DIFF - operand mux selects (external operand / difference)
//   MAX_ITER_DEF - default subtract-step limit (worst 8-bit case is 254)
//   ctl_t / ctl_of - Moore decode of the datapath controls for each state
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SUB_A,
        SUB_B,
        OUT,
        DONE,
        ERR
    } state_t;

    localparam logic SEL_EXT  = 1'b0;
    localparam logic SEL_DIFF = 1'b1;

    localparam int MAX_ITER_DEF = 255;

    typedef struct packed {
        logic a_ld;
        logic b_ld;
        logic a_sel;
        logic b_sel;
        logic output_en;
        logic busy;
        logic done;
    } ctl_t;

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        c.a_sel = SEL_EXT;
        c.b_sel = SEL_EXT;
        case (s)
            LOAD:  begin c.a_ld = 1'b1; c.b_ld = 1'b1; c.busy = 1'b1; end
            CHECK: begin c.busy = 1'b1; end
            SUB_A: begin c.a_ld = 1'b1; c.a_sel = SEL_DIFF; c.busy = 1'b1; end
            SUB_B: begin c.b_ld = 1'b1; c.b_sel = SEL_DIFF; c.busy = 1'b1; end
            OUT:   begin c.output_en = 1'b1; c.busy = 1'b1; end
            DONE:  begin c.done = 1'b1; c.busy = 1'b1; end
            ERR:   begin c.done = 1'b1; c.busy = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a subtract-and-compare GCD datapath.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   start             - request a new GCD, sampled only in IDLE
//   a_gt_b/a_lt_b/a_eq_b - comparator flags from the datapath
//   a_ld, b_ld        - operand register load enables
//   a_sel, b_sel      - operand mux selects (SEL_EXT / SEL_DIFF)
//   output_en         - result register load enable (captures B)
//   busy              - high from LOAD through DONE/ERR
//   done              - one-cycle completion pulse (also in ERR)
//   error             - sticky abort flag, cleared by the next accepted start
//   iter_cnt          - subtract steps taken in the current or last run
// All controls are registered alongside the state, so each output is a pure
// function of the current state and reset drops them all immediately.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_gt_b,
    input  logic              a_lt_b,
    input  logic              a_eq_b,
    output logic              a_ld,
    output logic              b_ld,
    output logic              a_sel,
    output logic              b_sel,
    output logic              output_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t            r_state;
    ctl_t              r_ctl;
    logic              r_error;
    logic [ITER_W-1:0] r_iter;

    logic [2:0] w_flags;
    logic       w_onehot;
    logic       w_iter_max;

    assign w_flags    = {a_gt_b, a_lt_b, a_eq_b};
    assign w_onehot   = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
    assign w_iter_max = (r_iter == ITER_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ctl   <= '0;
            r_error <= 1'b0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_ctl   <= ctl_of(LOAD);
                        r_iter  <= '0;
                        r_error <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state <= CHECK;
                    r_ctl   <= ctl_of(CHECK);
                end
                CHECK: begin
                    // Illegal flag patterns and step exhaustion both abort;
                    // equality takes priority over the step limit.
                    if (!w_onehot) begin
                        r_state <= ERR;
                        r_ctl   <= ctl_of(ERR);
                        r_error <= 1'b1;
                    end else if (a_eq_b) begin
                        r_state <= OUT;
                        r_ctl   <= ctl_of(OUT);
                    end else if (w_iter_max) begin
                        r_state <= ERR;
                        r_ctl   <= ctl_of(ERR);
                        r_error <= 1'b1;
                    end else if (a_gt_b) begin
                        r_state <= SUB_A;
                        r_ctl   <= ctl_of(SUB_A);
                        r_iter  <= r_iter + ITER_W'(1);
                    end else begin
                        r_state <= SUB_B;
                        r_ctl   <= ctl_of(SUB_B);
                        r_iter  <= r_iter + ITER_W'(1);
                    end
                end
                SUB_A, SUB_B: begin
                    r_state <= CHECK;
                    r_ctl   <= ctl_of(CHECK);
                end
                OUT: begin
                    r_state <= DONE;
                    r_ctl   <= ctl_of(DONE);
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_ctl   <= ctl_of(IDLE);
                end
                default: begin
                    r_state <= IDLE;
                    r_ctl   <= '0;
                end
            endcase
        end
    end

    assign a_ld      = r_ctl.a_ld;
    assign b_ld      = r_ctl.b_ld;
    assign a_sel     = r_ctl.a_sel;
    assign b_sel     = r_ctl.b_sel;
    assign output_en = r_ctl.output_en;
    assign busy      = r_ctl.busy;
    assign done      = r_ctl.done;
    assign error     = r_error;
    assign iter_cnt  = r_iter;

endmodule

// File: tb/tb_gcd_controller.sv
module tb_gcd_controller;

    localparam int MAXI = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       a_gt_b, a_lt_b, a_eq_b;
    logic       a_ld, b_ld, a_sel, b_sel, output_en, busy, done, error;
    logic [7:0] iter_cnt;

    gcd_controller #(.MAX_ITER(MAXI)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
        .a_ld(a_ld), .b_ld(b_ld), .a_sel(a_sel), .b_sel(b_sel),
        .output_en(output_en), .busy(busy), .done(done), .error(error),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural 8-bit datapath driven by the controller.
    logic [7:0] in1 = 8'd0, in2 = 8'd0;
    logic [7:0] rA = 8'd0, rB = 8'd0, rOut = 8'd0;
    logic       force_bad = 1'b0;

    always @(posedge clk) begin
        if (a_ld) rA <= a_sel ? rA - rB : in1;
        if (b_ld) rB <= b_sel ? rB - rA : in2;
        if (output_en) rOut <= rB;
    end

    assign a_gt_b = force_bad ? 1'b1 : (rA > rB);
    assign a_lt_b = force_bad ? 1'b1 : (rA < rB);
    assign a_eq_b = force_bad ? 1'b0 : (rA == rB);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: subtractive Euclid with a step limit.
    task automatic ref_gcd(input int a, input int b, output int g, output int n, output bit e);
        n = 0;
        while (a != b && n < MAXI) begin
            if (a > b) a = a - b; else b = b - a;
            n++;
        end
        e = (a != b);
        g = b;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         out;
        int         iter;
        bit         err;
        int         cyc;
    } vec_t;

    // Runs one operation; repulse > 0 re-asserts start during that cycle.
    task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input int e_out, input int e_iter, input bit e_err,
                       input int e_cyc, input int repulse);
        int cyc, oe_cnt, ld_late;
        logic [7:0] out_before;
        in1 = x; in2 = y;
        out_before = rOut;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1; oe_cnt = 0; ld_late = 0;
        check({tag, " err_clr"}, error, 0);
        check({tag, " load"}, {a_ld, b_ld, a_sel, b_sel, busy}, 5'b11001);
        while (!done && cyc < 1000) begin
            if (cyc == repulse) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (output_en) oe_cnt++;
            if (a_ld || b_ld) ld_late++;
        end
        check({tag, " done_cyc"}, cyc, e_cyc);
        check({tag, " iter"}, iter_cnt, e_iter);
        check({tag, " err"}, error, e_err);
        check({tag, " oe_cnt"}, oe_cnt, e_err ? 0 : 1);
        check({tag, " sub_lds"}, ld_late, e_iter);
        @(posedge clk); #1;
        check({tag, " out"}, rOut, e_err ? out_before : e_out);
        check({tag, " idle"}, {done, busy}, 0);
        check({tag, " err_hold"}, error, e_err);
    endtask

    initial begin
        vec_t tbl[5];
        int   g, n;
        bit   e;
        int   k;

        tbl[0] = '{a: 8'd12,  b: 8'd8, out: 4, iter: 2,   err: 1'b0, cyc: 8};
        tbl[1] = '{a: 8'd9,   b: 8'd9, out: 9, iter: 0,   err: 1'b0, cyc: 4};
        tbl[2] = '{a: 8'd255, b: 8'd1, out: 1, iter: 254, err: 1'b0, cyc: 512};
        tbl[3] = '{a: 8'd0,   b: 8'd5, out: 0, iter: 255, err: 1'b1, cyc: 513};
        tbl[4] = '{a: 8'd7,   b: 8'd0, out: 0, iter: 255, err: 1'b1, cyc: 513};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset outs", {a_ld, b_ld, a_sel, b_sel, output_en, busy, done, error}, 0);
        check("reset iter", iter_cnt, 0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 5; i++)
            run($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].out,
                tbl[i].iter, tbl[i].err, tbl[i].cyc, 0);

        // Error stays set through idle cycles until a start is accepted.
        repeat (3) @(posedge clk);
        #1;
        check("err sticky idle", error, 1);

        // Start re-pulsed while busy is ignored.
        run("repulse", 8'd12, 8'd8, 4, 2, 1'b0, 8, 3);

        // Randomized operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] x, y;
            x = (i < 8) ? 8'($urandom_range(1, 40)) : 8'($urandom_range(0, 255));
            y = (i < 8) ? 8'($urandom_range(1, 40)) : 8'($urandom_range(0, 255));
            ref_gcd(x, y, g, n, e);
            run($sformatf("rnd%0d(%0d,%0d)", i, x, y), x, y, g, n, e,
                e ? 2 * n + 3 : 2 * n + 4, 0);
        end

        // Illegal flag pattern in CHECK aborts on the next cycle.
        in1 = 8'd12; in2 = 8'd8;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; force_bad = 1'b1;
        @(posedge clk); #1;
        check("bad chk", {a_ld, b_ld, done, busy}, 4'b0001);
        @(posedge clk); #1;
        check("bad err", {done, error, output_en}, 3'b110);
        check("bad iter", iter_cnt, 0);
        force_bad = 1'b0;
        @(posedge clk); #1;
        check("bad after", {done, busy, error}, 3'b001);

        // Asynchronous reset during SUB_B.
        in1 = 8'd12; in2 = 8'd8;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (!(b_ld && b_sel) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach sub_b", (b_ld && b_sel) ? 1 : 0, 1);
        #2 rst = 1'b0;
        #1;
        check("async rst outs", {a_ld, b_ld, a_sel, b_sel, output_en, busy, done, error}, 0);
        check("async rst iter", iter_cnt, 0);
        @(negedge clk); rst = 1'b1;
        run("post_rst", 8'd12, 8'd8, 4, 2, 1'b0, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
